// File: rtl/pmem_line_responder.sv
// Line-level pmem target: a zero-initialised backing store that answers each
// read or write request with a single-cycle pmem_resp after a fixed latency.
module pmem_line_responder #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_mindex = 6,
  parameter int unsigned LATENCY  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata_256,
  output logic [255:0] pmem_rdata_256,
  output logic         pmem_resp,
  output logic         pmem_err
);

  localparam int unsigned Lines = 1 << s_mindex;
  localparam int unsigned IdxHi = s_offset + s_mindex;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e               state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [s_mindex-1:0]  idx_q;
  logic                 oor_q, rd_q, wr_q;
  logic [255:0]         wdata_q;
  logic                 err_q, err_d;
  logic [255:0]         store_q [Lines];

  logic [s_mindex-1:0]  idx_in;
  logic                 oor_in;
  logic                 latch_en;
  logic                 commit_en;
  logic [s_mindex-1:0]  commit_idx;
  logic [255:0]         commit_data;

  logic unused_offset;
  assign unused_offset = ^pmem_address[s_offset-1:0];

  assign idx_in = pmem_address[IdxHi-1:s_offset];
  assign oor_in = |pmem_address[31:IdxHi];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    latch_en    = 1'b0;
    commit_en   = 1'b0;
    commit_idx  = idx_q;
    commit_data = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (pmem_read || pmem_write) begin
          latch_en = 1'b1;
          count_d  = 4'(LATENCY - 1);
          if ((pmem_read && pmem_write) || oor_in) err_d = 1'b1;
          if (LATENCY == 1) begin
            // No BUSY phase: the write commits straight from the live inputs.
            state_d     = StResp;
            commit_en   = pmem_write && !pmem_read && !oor_in;
            commit_idx  = idx_in;
            commit_data = pmem_wdata_256;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        count_d = count_q - 4'd1;
        if (count_q <= 4'd1) begin
          state_d   = StResp;
          count_d   = 4'd0;
          commit_en = wr_q && !oor_q;
        end
      end
      StResp: begin
        state_d = StIdle;
        count_d = 4'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (latch_en) begin
        idx_q   <= idx_in;
        oor_q   <= oor_in;
        rd_q    <= pmem_read;
        // Simultaneous read/write is handled as a read only.
        wr_q    <= pmem_write && !pmem_read;
        wdata_q <= pmem_wdata_256;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Lines; i++) store_q[i] <= '0;
    end else if (commit_en) begin
      store_q[commit_idx] <= commit_data;
    end
  end

  assign pmem_resp      = (state_q == StResp);
  assign pmem_err       = err_q;
  assign pmem_rdata_256 = (state_q == StResp && rd_q && !oor_q) ? store_q[idx_q] : '0;

endmodule
